// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, branch resolution, EX/MEM register and data-memory request FSM.
// Build option FWD_MUX_EN: when defined, fwdA_sel/fwdB_sel/wb_fwd_data select forwarded operands.
package cpu_types_pkg;
    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;
endpackage

module execute_stage
    import cpu_types_pkg::*;
#(
    parameter int DW = 32,
    parameter int RW = 5
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          iHit,
    input  logic          flush,
    input  logic          dREN_in,
    input  logic          dWEN_in,
    input  logic          regWrite_in,
    input  logic          MemtoReg_in,
    input  logic          HALT_in,
    input  logic          aluSrc_in,
    input  logic          branch_in,
    input  logic          branchSel_in,
    input  logic [3:0]    ALUop_in,
    input  logic [DW-1:0] Imm_in,
    input  logic [DW-1:0] rdat1_in,
    input  logic [DW-1:0] rdat2_in,
    input  logic [DW-1:0] pcp4_in,
    input  logic [RW-1:0] wsel_in,
    input  logic [1:0]    fwdA_sel,
    input  logic [1:0]    fwdB_sel,
    input  logic [DW-1:0] wb_fwd_data,
    input  logic          dhit,
    input  logic [DW-1:0] dmemload,
    output logic          branch_taken,
    output logic [DW-1:0] branch_target,
    output logic          stall,
    output logic          dREN,
    output logic          dWEN,
    output logic [DW-1:0] daddr,
    output logic [DW-1:0] dstore,
    output logic [DW-1:0] alu_out_q,
    output logic [DW-1:0] load_q,
    output logic [RW-1:0] wsel_q,
    output logic          regWrite_q,
    output logic          MemtoReg_q,
    output logic          HALT_q,
    output logic          mem_valid,
    output logic [1:0]    state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    mem_state_t    state_q, state_d;
    logic [DW-1:0] rdat2_q, rdat2_d, alu_out_d, load_d;
    logic [RW-1:0] wsel_d;
    logic          dREN_q, dREN_d, dWEN_q, dWEN_d;
    logic          regWrite_d, MemtoReg_d, HALT_d;
    logic [DW-1:0] opa, fwd_b, opb, alu_res;
    logic          zero, en, mem_pending;

`ifdef FWD_MUX_EN
    always_comb begin
        case (fwdA_sel)
            2'b01:   opa = alu_out_q;
            2'b10:   opa = wb_fwd_data;
            default: opa = rdat1_in;
        endcase
        case (fwdB_sel)
            2'b01:   fwd_b = alu_out_q;
            2'b10:   fwd_b = wb_fwd_data;
            default: fwd_b = rdat2_in;
        endcase
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwdA_sel, fwdB_sel, wb_fwd_data};
    assign opa   = rdat1_in;
    assign fwd_b = rdat2_in;
`endif

    assign opb = aluSrc_in ? Imm_in : fwd_b;

    always_comb begin
        alu_res = '0;
        case (ALUop_in)
            ALU_SLL:  alu_res = opa << opb[4:0];
            ALU_SRL:  alu_res = opa >> opb[4:0];
            ALU_ADD:  alu_res = opa + opb;
            ALU_SUB:  alu_res = opa - opb;
            ALU_AND:  alu_res = opa & opb;
            ALU_OR:   alu_res = opa | opb;
            ALU_XOR:  alu_res = opa ^ opb;
            ALU_NOR:  alu_res = ~(opa | opb);
            ALU_SLT:  alu_res = {{(DW-1){1'b0}}, $signed(opa) < $signed(opb)};
            ALU_SLTU: alu_res = {{(DW-1){1'b0}}, opa < opb};
            default:  alu_res = '0;
        endcase
    end

    assign zero          = (alu_res == '0);
    assign branch_taken  = branch_in & (branchSel_in ? ~zero : zero);
    assign branch_target = pcp4_in + (Imm_in << 2);

    // A halted pipe never raises a new memory request.
    assign mem_pending = (dREN_q | dWEN_q) & ~HALT_q;

    // Cache handshake: dREN/dWEN stay asserted for every REQ cycle; the access
    // completes in the cycle dhit is high, and dhit outside REQ is ignored.
    always_comb begin
        state_d   = state_q;
        stall     = 1'b0;
        mem_valid = 1'b0;
        dREN      = 1'b0;
        dWEN      = 1'b0;
        load_d    = load_q;
        case (state_q)
            IDLE: begin
                if (mem_pending) begin
                    state_d = REQ;
                    stall   = 1'b1;
                end
            end
            REQ: begin
                dREN = dREN_q;
                dWEN = dWEN_q;
                if (dhit) begin
                    state_d = DONE;
                    if (dREN_q) load_d = dmemload;
                end else begin
                    stall = 1'b1;
                end
            end
            DONE: begin
                mem_valid = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign en = iHit & ~stall;

    always_comb begin
        alu_out_d  = alu_out_q;
        rdat2_d    = rdat2_q;
        wsel_d     = wsel_q;
        dREN_d     = dREN_q;
        dWEN_d     = dWEN_q;
        regWrite_d = regWrite_q;
        MemtoReg_d = MemtoReg_q;
        HALT_d     = HALT_q;
        if (en) begin
            if (flush) begin
                alu_out_d  = '0;
                rdat2_d    = '0;
                wsel_d     = '0;
                dREN_d     = 1'b0;
                dWEN_d     = 1'b0;
                regWrite_d = 1'b0;
                MemtoReg_d = 1'b0;
                HALT_d     = 1'b0;
            end else begin
                alu_out_d  = alu_res;
                rdat2_d    = fwd_b;
                wsel_d     = wsel_in;
                dREN_d     = dREN_in;
                dWEN_d     = dWEN_in;
                regWrite_d = regWrite_in;
                MemtoReg_d = MemtoReg_in;
                HALT_d     = HALT_in;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q    <= IDLE;
            alu_out_q  <= '0;
            rdat2_q    <= '0;
            load_q     <= '0;
            wsel_q     <= '0;
            dREN_q     <= 1'b0;
            dWEN_q     <= 1'b0;
            regWrite_q <= 1'b0;
            MemtoReg_q <= 1'b0;
            HALT_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_out_q  <= alu_out_d;
            rdat2_q    <= rdat2_d;
            load_q     <= load_d;
            wsel_q     <= wsel_d;
            dREN_q     <= dREN_d;
            dWEN_q     <= dWEN_d;
            regWrite_q <= regWrite_d;
            MemtoReg_q <= MemtoReg_d;
            HALT_q     <= HALT_d;
        end
    end

    assign daddr     = alu_out_q;
    assign dstore    = rdat2_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: ALU vector table, branch, forwarding, flush/iHit and memory FSM sequences.
module tb_execute_stage;
    import cpu_types_pkg::*;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          iHit, flush;
    logic          dREN_in, dWEN_in, regWrite_in, MemtoReg_in, HALT_in, aluSrc_in, branch_in, branchSel_in;
    logic [3:0]    ALUop_in;
    logic [DW-1:0] Imm_in, rdat1_in, rdat2_in, pcp4_in;
    logic [RW-1:0] wsel_in;
    logic [1:0]    fwdA_sel, fwdB_sel;
    logic [DW-1:0] wb_fwd_data;
    logic          dhit;
    logic [DW-1:0] dmemload;
    logic          branch_taken, stall, dREN, dWEN;
    logic [DW-1:0] branch_target, daddr, dstore, alu_out_q, load_q;
    logic [RW-1:0] wsel_q;
    logic          regWrite_q, MemtoReg_q, HALT_q, mem_valid;
    logic [1:0]    state_dbg;

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic [3:0]    op;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] imm;
        logic          src;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[15];

    execute_stage #(.DW(DW), .RW(RW)) dut (
        .CLK(CLK), .nRST(nRST), .iHit(iHit), .flush(flush),
        .dREN_in(dREN_in), .dWEN_in(dWEN_in), .regWrite_in(regWrite_in), .MemtoReg_in(MemtoReg_in),
        .HALT_in(HALT_in), .aluSrc_in(aluSrc_in), .branch_in(branch_in), .branchSel_in(branchSel_in),
        .ALUop_in(ALUop_in), .Imm_in(Imm_in), .rdat1_in(rdat1_in), .rdat2_in(rdat2_in), .pcp4_in(pcp4_in),
        .wsel_in(wsel_in), .fwdA_sel(fwdA_sel), .fwdB_sel(fwdB_sel), .wb_fwd_data(wb_fwd_data),
        .dhit(dhit), .dmemload(dmemload),
        .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .alu_out_q(alu_out_q), .load_q(load_q), .wsel_q(wsel_q),
        .regWrite_q(regWrite_q), .MemtoReg_q(MemtoReg_q), .HALT_q(HALT_q),
        .mem_valid(mem_valid), .state_dbg(state_dbg)
    );

    // Clock
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic sb_pop(input string name, input logic [DW-1:0] act);
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: got 0x%08h with no expected value queued", name, act);
        end else begin
            chk(name, act, exp_q.pop_front());
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        iHit = 1'b1; flush = 1'b0;
        dREN_in = 1'b0; dWEN_in = 1'b0; regWrite_in = 1'b0; MemtoReg_in = 1'b0;
        HALT_in = 1'b0; aluSrc_in = 1'b0; branch_in = 1'b0; branchSel_in = 1'b0;
        ALUop_in = 4'd0; Imm_in = '0; rdat1_in = '0; rdat2_in = '0; pcp4_in = '0;
        wsel_in = '0; fwdA_sel = 2'b00; fwdB_sel = 2'b00; wb_fwd_data = '0;
        dhit = 1'b0; dmemload = '0;
    endtask

    task automatic drive_op(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [DW-1:0] imm, input logic src, input logic [RW-1:0] ws);
        ALUop_in = op; rdat1_in = a; rdat2_in = b; Imm_in = imm; aluSrc_in = src; wsel_in = ws;
    endtask

    initial begin
        bit got;
        logic [DW-1:0] fwd_exp;

        vecs[0]  = '{ALU_ADD,  32'hFFFF_FFFF, 32'h1,          32'h0,  1'b0, 32'h0};
        vecs[1]  = '{ALU_SUB,  32'h0,         32'h1,          32'h0,  1'b0, 32'hFFFF_FFFF};
        vecs[2]  = '{ALU_SLT,  32'hFFFF_FFFF, 32'h1,          32'h0,  1'b0, 32'h1};
        vecs[3]  = '{ALU_SLTU, 32'hFFFF_FFFF, 32'h1,          32'h0,  1'b0, 32'h0};
        vecs[4]  = '{ALU_SLT,  32'h1,         32'hFFFF_FFFF,  32'h0,  1'b0, 32'h0};
        vecs[5]  = '{ALU_SLTU, 32'h1,         32'hFFFF_FFFF,  32'h0,  1'b0, 32'h1};
        vecs[6]  = '{ALU_SLL,  32'h1,         32'd35,         32'h0,  1'b0, 32'h8};
        vecs[7]  = '{ALU_SRL,  32'h8000_0000, 32'd31,         32'h0,  1'b0, 32'h1};
        vecs[8]  = '{ALU_AND,  32'hF0F0,      32'hFF00,       32'h0,  1'b0, 32'hF000};
        vecs[9]  = '{ALU_OR,   32'hF0F0,      32'hFF00,       32'h0,  1'b0, 32'hFFF0};
        vecs[10] = '{ALU_XOR,  32'hF0F0,      32'hFF00,       32'h0,  1'b0, 32'h0FF0};
        vecs[11] = '{ALU_NOR,  32'h0,         32'h0,          32'h0,  1'b0, 32'hFFFF_FFFF};
        vecs[12] = '{4'd15,    32'h5,         32'h5,          32'h0,  1'b0, 32'h0};
        vecs[13] = '{ALU_ADD,  32'd10,        32'h999,        32'h20, 1'b1, 32'h2A};
        vecs[14] = '{ALU_SUB,  32'h7,         32'h7,          32'h0,  1'b0, 32'h0};

        // Reset with random inputs for two cycles
        clear_inputs();
        nRST = 1'b0;
        for (int c = 0; c < 2; c++) begin
            iHit = 1'($urandom_range(0, 1)); flush = 1'($urandom_range(0, 1));
            dREN_in = 1'($urandom_range(0, 1)); dWEN_in = 1'($urandom_range(0, 1));
            regWrite_in = 1'($urandom_range(0, 1)); MemtoReg_in = 1'($urandom_range(0, 1));
            HALT_in = 1'($urandom_range(0, 1)); ALUop_in = 4'($urandom_range(0, 15));
            rdat1_in = $urandom; rdat2_in = $urandom; Imm_in = $urandom;
            wsel_in = 5'($urandom_range(0, 31)); dhit = 1'($urandom_range(0, 1)); dmemload = $urandom;
            step();
        end
        chk("rst_alu_out_q", alu_out_q, 32'h0);
        chk("rst_load_q", load_q, 32'h0);
        chk("rst_wsel_q", 32'(wsel_q), 32'h0);
        chk("rst_dstore", dstore, 32'h0);
        chk1("rst_regWrite_q", regWrite_q, 1'b0);
        chk1("rst_MemtoReg_q", MemtoReg_q, 1'b0);
        chk1("rst_HALT_q", HALT_q, 1'b0);
        chk1("rst_dREN", dREN, 1'b0);
        chk1("rst_dWEN", dWEN, 1'b0);
        chk1("rst_stall", stall, 1'b0);
        chk1("rst_mem_valid", mem_valid, 1'b0);
        chk("rst_state", 32'(state_dbg), 32'h0);
        nRST = 1'b1;
        clear_inputs();
        step();

        // ALU vector table through the scoreboard
        for (int i = 0; i < 15; i++) begin
            drive_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].src, 5'd1);
            exp_q.push_back(vecs[i].exp);
            step();
            sb_pop($sformatf("alu_vec%0d", i), alu_out_q);
        end

        // Branch resolution (combinational)
        clear_inputs();
        drive_op(ALU_SUB, 32'd5, 32'd5, 32'd4, 1'b0, 5'd0);
        branch_in = 1'b1; pcp4_in = 32'h100;
        #1;
        chk1("br_beq_taken", branch_taken, 1'b1);
        chk("br_target", branch_target, 32'h110);
        branchSel_in = 1'b1;
        #1;
        chk1("br_bne_equal", branch_taken, 1'b0);
        rdat2_in = 32'd6;
        #1;
        chk1("br_bne_diff", branch_taken, 1'b1);
        branch_in = 1'b0;
        #1;
        chk1("br_no_branch", branch_taken, 1'b0);
        step();

        // Forwarding
        clear_inputs();
        drive_op(ALU_ADD, 32'd3, 32'd4, 32'd0, 1'b0, 5'd2);
        exp_q.push_back(32'd7);
        step();
        sb_pop("fwd_setup", alu_out_q);
        drive_op(ALU_SUB, 32'd100, 32'd50, 32'd0, 1'b0, 5'd2);
        fwdA_sel = 2'b01; fwdB_sel = 2'b10; wb_fwd_data = 32'd3;
`ifdef FWD_MUX_EN
        fwd_exp = 32'd4;
`else
        fwd_exp = 32'd50;
`endif
        exp_q.push_back(fwd_exp);
        step();
        sb_pop("fwd_sub", alu_out_q);

        // Flush and iHit
        clear_inputs();
        drive_op(ALU_ADD, 32'd1, 32'd1, 32'd0, 1'b0, 5'd7);
        regWrite_in = 1'b1;
        step();
        chk1("fl_pre_regWrite", regWrite_q, 1'b1);
        chk("fl_pre_wsel", 32'(wsel_q), 32'd7);
        flush = 1'b1;
        step();
        chk1("fl_regWrite", regWrite_q, 1'b0);
        chk("fl_wsel", 32'(wsel_q), 32'd0);
        chk("fl_alu_out", alu_out_q, 32'd0);
        flush = 1'b0;
        drive_op(ALU_ADD, 32'd2, 32'd2, 32'd0, 1'b0, 5'd9);
        step();
        chk("ih_load_alu", alu_out_q, 32'd4);
        iHit = 1'b0;
        drive_op(ALU_ADD, 32'd10, 32'd10, 32'd0, 1'b0, 5'd12);
        MemtoReg_in = 1'b1; regWrite_in = 1'b0;
        step();
        chk("ih_hold_alu", alu_out_q, 32'd4);
        chk("ih_hold_wsel", 32'(wsel_q), 32'd9);
        chk1("ih_hold_regWrite", regWrite_q, 1'b1);
        chk1("ih_hold_MemtoReg", MemtoReg_q, 1'b0);

        // Load with a three-cycle miss, flush held high during the stall
        clear_inputs();
        drive_op(ALU_ADD, 32'h40, 32'h0, 32'd8, 1'b1, 5'd3);
        dREN_in = 1'b1; regWrite_in = 1'b1; MemtoReg_in = 1'b1;
        exp_q.push_back(32'hDEAD_BEEF);
        step();
        chk1("ld_idle_stall", stall, 1'b1);
        chk1("ld_idle_dREN", dREN, 1'b0);
        chk("ld_daddr", daddr, 32'h48);
        dREN_in = 1'b0; MemtoReg_in = 1'b0;
        drive_op(ALU_ADD, 32'd1, 32'd2, 32'd0, 1'b0, 5'd5);
        flush = 1'b1;
        step();
        for (int c = 0; c < 3; c++) begin
            chk1($sformatf("ld_req_dREN%0d", c), dREN, 1'b1);
            chk1($sformatf("ld_req_stall%0d", c), stall, 1'b1);
            chk($sformatf("ld_req_daddr%0d", c), daddr, 32'h48);
            chk($sformatf("ld_req_wsel%0d", c), 32'(wsel_q), 32'd3);
            step();
        end
        flush = 1'b0;
        dhit = 1'b1; dmemload = 32'hDEAD_BEEF;
        #1;
        chk1("ld_hit_stall", stall, 1'b0);
        step();
        dhit = 1'b0; dmemload = 32'h0;
        got = 1'b0;
        for (int c = 0; c < 8 && !got; c++) begin
            if (mem_valid) got = 1'b1;
            else step();
        end
        if (!got) begin
            chk1("ld_mem_valid_timeout", 1'b0, 1'b1);
        end else begin
            sb_pop("ld_load_q", load_q);
            chk("ld_next_alu", alu_out_q, 32'd3);
            chk("ld_next_wsel", 32'(wsel_q), 32'd5);
            chk1("ld_done_stall", stall, 1'b0);
            chk1("ld_done_dREN", dREN, 1'b0);
        end
        step();
        chk1("ld_pulse_end", mem_valid, 1'b0);
        chk("ld_back_idle", 32'(state_dbg), 32'h0);

        // Store: write request, load_q untouched
        clear_inputs();
        drive_op(ALU_ADD, 32'h100, 32'h55, 32'd4, 1'b1, 5'd0);
        dWEN_in = 1'b1;
        step();
        clear_inputs();
        step();
        chk1("st_dWEN", dWEN, 1'b1);
        chk1("st_dREN", dREN, 1'b0);
        chk("st_dstore", dstore, 32'h55);
        chk("st_daddr", daddr, 32'h104);
        dhit = 1'b1; dmemload = 32'h1234_5678;
        step();
        dhit = 1'b0;
        chk1("st_mem_valid", mem_valid, 1'b1);
        chk("st_load_q_kept", load_q, 32'hDEAD_BEEF);
        step();

        // HALT suppresses memory requests
        clear_inputs();
        drive_op(ALU_ADD, 32'h10, 32'h0, 32'd0, 1'b0, 5'd0);
        HALT_in = 1'b1; dREN_in = 1'b1;
        step();
        chk1("halt_q", HALT_q, 1'b1);
        chk1("halt_no_stall", stall, 1'b0);
        step();
        chk1("halt_no_dREN", dREN, 1'b0);
        chk("halt_state", 32'(state_dbg), 32'h0);
        clear_inputs();
        step();

        // Reset in the middle of a request
        drive_op(ALU_ADD, 32'h80, 32'h0, 32'd0, 1'b0, 5'd4);
        dREN_in = 1'b1;
        step();
        clear_inputs();
        step();
        chk("mr_in_req", 32'(state_dbg), 32'h1);
        nRST = 1'b0;
        step();
        chk1("mr_dREN", dREN, 1'b0);
        chk1("mr_stall", stall, 1'b0);
        chk("mr_state", 32'(state_dbg), 32'h0);
        chk("mr_alu_out", alu_out_q, 32'h0);
        nRST = 1'b1;
        step();

        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
